// File: rtl/us_ranger_pkg.sv
// Shared types and constants for the us_ranger_mc ultrasonic ranging controller.
// Timing defaults assume a 50 MHz clock and HC-SR04-class sensors.
package us_ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLD
  } state_e;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_DIST_W         = 9;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_SLOT_CYCLES    = 3_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 1_900_000;
  localparam int DEF_CYCLES_PER_CM  = 2900;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/us_ranger_mc_echo_sync.sv
// Two-flop synchronizer for the raw echo lines plus rise/fall detection
// on the synchronized level (one extra history flop per channel).
module echo_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] echo_raw,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // NOTE: non-blocking assignments make the three stages shift by one per clock instead of collapsing into one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= echo_raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/us_ranger_mc.sv
// Round-robin multi-channel ultrasonic ranger: triggers one sensor per slot,
// times its echo in whole cm, holds per-channel results. Option: US_RANGER_NEAREST_EN.
module us_ranger_mc
  import us_ranger_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int DIST_W         = DEF_DIST_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int SLOT_CYCLES    = DEF_SLOT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          echo,
  output logic [NUM_CH-1:0]          trig,
  output logic [NUM_CH*DIST_W-1:0]   distance,
  output logic [NUM_CH-1:0]          timeout,
  output logic                       dist_valid,
  output logic [clog2(NUM_CH)-1:0]   dist_ch
`ifdef US_RANGER_NEAREST_EN
  ,
  output logic [DIST_W-1:0]          nearest_dist,
  output logic [clog2(NUM_CH)-1:0]   nearest_ch
`endif
);

  localparam int CH_W   = clog2(NUM_CH);
  localparam int SLOT_W = clog2(SLOT_CYCLES);
  localparam int TRIG_W = clog2(TRIG_CYCLES);
  localparam int TO_W   = clog2(TIMEOUT_CYCLES);
  localparam int PRE_W  = clog2(CYCLES_PER_CM);

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] DIST_MAX  = '1;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [TRIG_W-1:0]   trig_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [PRE_W-1:0]    pre_cnt, pre_base, pre_next;
  logic [DIST_W-1:0]   cm_cnt, cm_base, cm_next;
  logic                pre_wrap, capture, cap_timeout;
  logic [NUM_CH-1:0]   echo_rise, echo_fall;
  logic [DIST_W-1:0]   dist_q [NUM_CH];

  echo_sync #(.WIDTH(NUM_CH)) u_echo_sync (
    .clock    (clock),
    .reset    (reset),
    .echo_raw (echo),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  wire sel_rise  = echo_rise[ch_q];
  wire sel_fall  = echo_fall[ch_q];
  wire slot_end  = (slot_cnt == SLOT_LAST);
  wire trig_done = (trig_cnt == TRIG_LAST);
  wire to_hit    = (to_cnt == TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    trig        = '0;
    // The rising-edge cycle counts as the first echo-high clock.
    pre_base = (state_q == MEASURE) ? pre_cnt : '0;
    cm_base  = (state_q == MEASURE) ? cm_cnt : '0;
    pre_wrap = (pre_base == PRE_LAST);
    pre_next = pre_wrap ? '0 : pre_base + 1'b1;
    cm_next  = (pre_wrap && cm_base != DIST_MAX) ? cm_base + 1'b1 : cm_base;
    unique case (state_q)
      IDLE: if (enable) state_d = TRIG;
      TRIG: begin
        trig[ch_q] = 1'b1;
        if (trig_done) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (to_hit) begin
          capture = 1'b1; cap_timeout = 1'b1; state_d = HOLD;
        end else if (sel_rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (to_hit) begin
          capture = 1'b1; cap_timeout = 1'b1; state_d = HOLD;
        end else if (sel_fall) begin
          capture = 1'b1; state_d = HOLD;
        end
      end
      HOLD: if (slot_end) state_d = enable ? TRIG : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_q     <= '0;
      slot_cnt <= '0;
      trig_cnt <= '0;
      to_cnt   <= '0;
      pre_cnt  <= '0;
      cm_cnt   <= '0;
    end else begin
      if (state_q == IDLE || (state_q == HOLD && slot_end)) slot_cnt <= '0;
      else if (!slot_end)                                   slot_cnt <= slot_cnt + 1'b1;
      trig_cnt <= (state_q == TRIG) ? trig_cnt + 1'b1 : '0;
      to_cnt   <= (state_q == WAIT_RISE || state_q == MEASURE) ? to_cnt + 1'b1 : '0;
      if ((state_q == WAIT_RISE && sel_rise) || (state_q == MEASURE && !sel_fall)) begin
        pre_cnt <= pre_next;
        cm_cnt  <= cm_next;
      end
      if (state_q == HOLD && slot_end) ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    end
  end

  // NOTE: the per-channel results are a small flop bank, not a RAM, so they take the async reset like any other state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) dist_q[i] <= '0;
      timeout    <= '0;
      dist_valid <= 1'b0;
      dist_ch    <= '0;
    end else begin
      dist_valid <= capture;
      if (capture) begin
        dist_q[ch_q]  <= cap_timeout ? DIST_MAX : cm_cnt;
        timeout[ch_q] <= cap_timeout;
        dist_ch       <= ch_q;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign distance[k*DIST_W +: DIST_W] = dist_q[k];
  end

`ifdef US_RANGER_NEAREST_EN
  logic [DIST_W-1:0] best_d;
  logic [CH_W-1:0]   best_c;
  logic              found;

  // Strict less-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    best_d = DIST_MAX;
    best_c = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!timeout[i] && (!found || dist_q[i] < best_d)) begin
        best_d = dist_q[i];
        best_c = CH_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nearest_dist <= '0;
      nearest_ch   <= '0;
    end else if (dist_valid) begin
      nearest_dist <= best_d;
      nearest_ch   <= best_c;
    end
  end
`endif

`ifndef SYNTHESIS
  param_ok: assert property (@(posedge clock) (TRIG_CYCLES + TIMEOUT_CYCLES + 4 < SLOT_CYCLES));
`endif

endmodule
